clkdiv_ctrl: RTL and testbench

Run-time controller for the board's toggle-type clock divider. It owns the divide counter and adds three things: start/stop gating, a valid/ready port for loading a new divide value, and glitch-free application of that value at half-period boundaries. It sits between the register/control logic and every consumer of the slow clock, such as the 1 Hz display and LED timing.

---
 rtl/clkdiv_pkg.sv | 19 +
 rtl/clkdiv_core.sv | 64 ++++++
 rtl/clkdiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the run-time clock divider controller:
//   state_t             - controller state (STOP, RUN, DRAIN)
//   CLKDIV_WIDTH        - default counter / divisor width
//   CLKDIV_DEFAULT_DIV  - default divisor loaded at reset
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned CLKDIV_WIDTH       = 25;
    localparam int unsigned CLKDIV_DEFAULT_DIV = 62500;

endpackage

// File: rtl/clkdiv_core.sv
// -----------------------------------------------------------------------------
// clkdiv_core
// Toggle-type divide counter with its active divisor register.
// While iRun is high the counter climbs to the divisor and then wraps to 0,
// toggling oClk, so each half-period lasts div+1 cycles. While iRun is low the
// counter and oClk are held at 0.
// Ports:
//   iClk, iRst_n - clock, asynchronous active-low reset
//   iRun         - count enable (low = held idle)
//   iLoad        - replace the divisor on this edge
//   iLoadVal     - divisor value written when iLoad is high
//   oClk         - divided clock (registered)
//   oBoundary    - this cycle ends a half-period (combinational, internal use)
//   oDiv         - divisor currently in use (registered)
// -----------------------------------------------------------------------------
module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = CLKDIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iRun,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadVal,
    output logic             oClk,
    output logic             oBoundary,
    output logic [WIDTH-1:0] oDiv
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic             r_clk;

    // >= rather than == so a counter can never run past a smaller divisor
    assign oBoundary = iRun && (r_cnt >= r_div);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
            r_div <= WIDTH'(DEFAULT_DIV);
        end else begin
            if (!iRun) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (oBoundary) begin
                r_cnt <= '0;
                r_clk <= ~r_clk;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end

            if (iLoad) begin
                r_div <= iLoadVal;
            end
        end
    end

    assign oClk = r_clk;
    assign oDiv = r_div;

endmodule

// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl
// Run-time controller for the toggle-type clock divider: start/stop gating,
// valid/ready divisor loading, and glitch-free divisor changes applied only at
// half-period boundaries (or immediately while stopped).
// Optional build macro: CLKDIV_CTRL_TICK_EN enables oTick generation; when
// undefined oTick is tied to 0.
// Ports:
//   iClk, iRst_n - clock, asynchronous active-low reset
//   iEn          - run request (low = stop after the current high phase)
//   iCfgValid    - new divisor offered
//   iCfgDiv      - offered divisor
//   oCfgReady    - a divisor can be accepted
//   oClk         - divided clock
//   oTick        - one-cycle pulse with each oClk rise
//   oBusy        - controller is not stopped
//   oDiv         - divisor currently in use
// -----------------------------------------------------------------------------
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = CLKDIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    input  logic             iCfgValid,
    input  logic [WIDTH-1:0] iCfgDiv,
    output logic             oCfgReady,
    output logic             oClk,
    output logic             oTick,
    output logic             oBusy,
    output logic [WIDTH-1:0] oDiv
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_vld;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_cfg_ready;
    logic             r_busy;

    logic             w_pend_vld_nxt;
    logic [WIDTH-1:0] w_pend_div_nxt;
    logic             w_run;
    logic             w_bnd;
    logic             w_clk;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;

    assign w_run    = (r_state != ST_STOP);
    assign w_accept = iCfgValid & r_cfg_ready;

    clkdiv_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iRun      (w_run),
        .iLoad     (w_load),
        .iLoadVal  (w_load_val),
        .oClk      (w_clk),
        .oBoundary (w_bnd),
        .oDiv      (oDiv)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state     <= ST_STOP;
            r_pend_vld  <= 1'b0;
            r_pend_div  <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_div  <= w_pend_div_nxt;
            r_cfg_ready <= ~w_pend_vld_nxt;
            r_busy      <= (w_state_nxt != ST_STOP);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_div_nxt = r_pend_div;
        w_load         = 1'b0;
        w_load_val     = r_pend_div;

        case (r_state)
            ST_STOP: begin
                // A value accepted on the last DRAIN boundary lands here;
                // ready is low then, so it cannot collide with a new offer.
                if (r_pend_vld) begin
                    w_load         = 1'b1;
                    w_pend_vld_nxt = 1'b0;
                end else if (w_accept) begin
                    w_load     = 1'b1;
                    w_load_val = iCfgDiv;
                end
                if (iEn) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!iEn) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stop only on the falling boundary so the high phase is whole
                if (iEn) begin
                    w_state_nxt = ST_RUN;
                end else if (w_bnd && w_clk) begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase

        if (w_run) begin
            // Accept requires no pending value, so these never overlap and a
            // value accepted on a boundary waits for the following one.
            if (w_bnd && r_pend_vld) begin
                w_load         = 1'b1;
                w_pend_vld_nxt = 1'b0;
            end
            if (w_accept) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_div_nxt = iCfgDiv;
            end
        end
    end

`ifdef CLKDIV_CTRL_TICK_EN
    logic r_tick;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_bnd & ~w_clk;
        end
    end

    assign oTick = r_tick;
`else
    assign oTick = 1'b0;
`endif

    assign oCfgReady = r_cfg_ready;
    assign oClk      = w_clk;
    assign oBusy     = r_busy;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
module tb_clkdiv_ctrl;

    localparam int W = 25;

    logic         iClk;
    logic         iRst_n;
    logic         iEn;
    logic         iCfgValid;
    logic [W-1:0] iCfgDiv;
    logic         oCfgReady;
    logic         oClk;
    logic         oTick;
    logic         oBusy;
    logic [W-1:0] oDiv;

    clkdiv_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (3)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iEn       (iEn),
        .iCfgValid (iCfgValid),
        .iCfgDiv   (iCfgDiv),
        .oCfgReady (oCfgReady),
        .oClk      (oClk),
        .oTick     (oTick),
        .oBusy     (oBusy),
        .oDiv      (oDiv)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks cycles left in the current half-period rather
    // than an up-counter, plus a queue holding at most one pending divisor.
    bit           m_active;
    bit           m_stopping;
    int           m_left;
    bit           m_clk;
    bit           m_tick;
    logic [W-1:0] m_div;
    logic [W-1:0] m_pend[$];
    bit           m_ready;
    bit           last_acc;
    int           n_tick_dut;
    int           n_tick_ref;

    function automatic void model_reset();
        m_active   = 0;
        m_stopping = 0;
        m_left     = 0;
        m_clk      = 0;
        m_tick     = 0;
        m_div      = W'(3);
        m_pend.delete();
        m_ready    = 1;
    endfunction

    function automatic void model_step(input bit rst_n_s, input bit en, input bit cv,
                                       input logic [W-1:0] cd);
        bit acc;
        if (!rst_n_s) begin
            model_reset();
            last_acc = 0;
            return;
        end
        acc      = cv && m_ready;
        last_acc = acc;
        m_tick   = 0;
        if (!m_active) begin
            m_clk = 0;
            if (m_pend.size() > 0) m_div = m_pend.pop_front();
            else if (acc)          m_div = cd;
            if (en) begin
                m_active   = 1;
                m_stopping = 0;
                m_left     = int'(m_div) + 1;
            end
        end else begin
            if (m_left == 1) begin
                m_clk  = !m_clk;
                m_tick = m_clk;
                if (m_pend.size() > 0) m_div = m_pend.pop_front();
                m_left = int'(m_div) + 1;
                if (m_stopping && !en && !m_clk) m_active = 0;
            end else begin
                m_left--;
            end
            if (acc) m_pend.push_back(cd);
            m_stopping = !en;
        end
        m_ready = (m_pend.size() == 0);
    endfunction

    task automatic compare_all();
        logic exp_tick;
`ifdef CLKDIV_CTRL_TICK_EN
        exp_tick = m_tick;
`else
        exp_tick = 1'b0;
`endif
        check("oClk",      32'(oClk),      32'(m_clk));
        check("oTick",     32'(oTick),     32'(exp_tick));
        check("oBusy",     32'(oBusy),     32'(m_active));
        check("oCfgReady", 32'(oCfgReady), 32'(m_ready));
        check("oDiv",      32'(oDiv),      32'(m_div));
    endtask

    task automatic tick_cycle();
        logic         r_s, en_s, cv_s;
        logic [W-1:0] cd_s;
        r_s  = iRst_n;
        en_s = iEn;
        cv_s = iCfgValid;
        cd_s = iCfgDiv;
        @(posedge iClk);
        model_step(r_s, en_s, cv_s, cd_s);
        #1;
        if (oTick) n_tick_dut++;
        if (m_tick) n_tick_ref++;
        compare_all();
    endtask

    task automatic wait_clk(input logic lvl, input int max, output int n);
        n = 0;
        while (oClk !== lvl && n < max) begin
            tick_cycle();
            n++;
        end
        if (oClk !== lvl) check("wait_oClk_timeout", 32'(oClk), 32'(lvl));
    endtask

    task automatic offer(input logic [W-1:0] v, input int max, output int n);
        iCfgValid = 1'b1;
        iCfgDiv   = v;
        n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!last_acc && n < max);
        if (!last_acc) check("offer_timeout", 32'(v), 32'hFFFF_FFFF);
    endtask

    task automatic async_reset();
        #2;
        iRst_n = 1'b0;
        #1;
        model_reset();
        last_acc = 0;
        check("rst_oClk",      32'(oClk),      32'd0);
        check("rst_oDiv",      32'(oDiv),      32'd3);
        check("rst_oCfgReady", 32'(oCfgReady), 32'd1);
        check("rst_oBusy",     32'(oBusy),     32'd0);
        check("rst_oTick",     32'(oTick),     32'd0);
    endtask

    initial begin : main
        int n;
        model_reset();
        last_acc   = 0;
        n_tick_dut = 0;
        n_tick_ref = 0;
        iRst_n     = 1'b0;
        iEn        = 1'b0;
        iCfgValid  = 1'b0;
        iCfgDiv    = '0;
        repeat (2) tick_cycle();

        // 1: start from reset with iEn held high
        iRst_n = 1'b1;
        iEn    = 1'b1;
        wait_clk(1'b1, 40, n);
        check("s1_first_rise", 32'(n), 32'd5);
        wait_clk(1'b0, 40, n);
        check("s1_high_len", 32'(n), 32'd4);
        wait_clk(1'b1, 40, n);
        check("s1_low_len", 32'(n), 32'd4);

        // 2: reconfigure to 1 during the high phase
        tick_cycle();
        iCfgValid = 1'b1;
        iCfgDiv   = W'(1);
        tick_cycle();
        check("s2_accepted", 32'(last_acc), 32'd1);
        check("s2_ready_low", 32'(oCfgReady), 32'd0);
        iCfgValid = 1'b0;
        iCfgDiv   = W'($urandom_range(0, 20));
        wait_clk(1'b0, 40, n);
        check("s2_old_half", 32'(n + 2), 32'd4);
        check("s2_ready_back", 32'(oCfgReady), 32'd1);
        wait_clk(1'b1, 40, n);
        check("s2_new_low", 32'(n), 32'd2);
        wait_clk(1'b0, 40, n);
        check("s2_new_high", 32'(n), 32'd2);

        // 3: back-to-back offers 5 then 0 with valid held
        offer(W'(5), 50, n);
        check("s3_div_before5", 32'(oDiv), 32'd1);
        offer(W'(0), 50, n);
        check("s3_wait0", 32'(n > 1), 32'd1);
        check("s3_div_at0", 32'(oDiv), 32'd5);
        iCfgValid = 1'b0;
        repeat (20) tick_cycle();
        check("s3_div_final", 32'(oDiv), 32'd0);

        // 4: stop while oClk is low
        wait_clk(1'b0, 10, n);
        iEn = 1'b0;
        n = 0;
        while (oBusy && n < 50) begin
            tick_cycle();
            n++;
        end
        check("s4_stopped", 32'(oBusy), 32'd0);
        check("s4_clk_low", 32'(oClk), 32'd0);
        repeat (6) tick_cycle();
        check("s4_clk_stays", 32'(oClk), 32'd0);

        // 5: configure 7 in STOP, then restart
        iCfgValid = 1'b1;
        iCfgDiv   = W'(7);
        tick_cycle();
        iCfgValid = 1'b0;
        check("s5_div", 32'(oDiv), 32'd7);
        check("s5_ready", 32'(oCfgReady), 32'd1);
        iEn = 1'b1;
        wait_clk(1'b1, 40, n);
        check("s5_first_rise", 32'(n), 32'd9);

        // 6: reset with a divisor pending
        iCfgValid = 1'b1;
        iCfgDiv   = W'(2);
        tick_cycle();
        iCfgValid = 1'b0;
        check("s6_pending", 32'(oCfgReady), 32'd0);
        async_reset();
        repeat (2) tick_cycle();
        iRst_n = 1'b1;
        repeat (30) tick_cycle();
        check("s6_div_kept", 32'(oDiv), 32'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) iEn = ~iEn;
            if (last_acc) iCfgValid = 1'b0;
            if (!iCfgValid && $urandom_range(0, 5) == 0) iCfgValid = 1'b1;
            if ($urandom_range(0, 3) == 0) iCfgDiv = W'($urandom_range(0, 9));
            if ($urandom_range(0, 999) == 0) begin
                async_reset();
                tick_cycle();
                iRst_n = 1'b1;
            end
            tick_cycle();
        end

`ifdef CLKDIV_CTRL_TICK_EN
        check("tick_total", 32'(n_tick_dut), 32'(n_tick_ref));
`else
        check("tick_total", 32'(n_tick_dut), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
